// File: rtl/fb_reader.sv
// fb_reader: walks a framebuffer one pixel per PLB single-beat read and pushes (x,y,color) records into a FIFO
module fb_reader #(
  parameter logic [31:0] FB_BASE   = 32'h0000_0000,
  parameter int          FB_WIDTH  = 640,
  parameter int          FB_HEIGHT = 480
) (
  input  logic        PLB_clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic [3:0]  state,
  output logic        IP2Bus_MstRd_Req,
  output logic [31:0] IP2Bus_Mst_Addr,
  input  logic        Bus2IP_Mst_CmdAck,
  input  logic        Bus2IP_Mst_Cmplt,
  input  logic [31:0] Bus2IP_MstRd_d,
  output logic        fifo_wr_en,
  output logic [95:0] fifo_data,
  input  logic        fifo_full
);
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WAIT_SPACE = 4'd1,
    REQ        = 4'd2,
    WAIT_CMPLT = 4'd3,
    PUSH       = 4'd4,
    DONE       = 4'd5
  } state_t;
  localparam logic [15:0] X_LAST = 16'(FB_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(FB_HEIGHT - 1);
  state_t      r_state, w_st, w_next;
  logic [15:0] r_x, r_y;
  logic [31:0] r_addr, r_color;
  logic        w_cap, w_xlast, w_last;
  assign w_st    = (r_state > DONE) ? IDLE : r_state;
  assign w_cap   = (w_st == REQ && Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) || (w_st == WAIT_CMPLT && Bus2IP_Mst_Cmplt);
  assign w_xlast = r_x == X_LAST;
  assign w_last  = w_xlast && r_y == Y_LAST;
  assign state            = w_st;
  assign busy             = w_st != IDLE;
  assign frame_done       = w_st == DONE;
  assign fifo_wr_en       = w_st == PUSH;
  assign IP2Bus_MstRd_Req = w_st == REQ;
  assign IP2Bus_Mst_Addr  = r_addr;
  assign fifo_data        = {r_x, r_y, 32'h0, r_color};
  // next-state: one outstanding read at a time, gated by FIFO space before each request
  always_comb begin
    w_next = IDLE;
    case (w_st)
      IDLE:       w_next = frame_start ? WAIT_SPACE : IDLE;
      WAIT_SPACE: w_next = fifo_full ? WAIT_SPACE : REQ;
      REQ:        w_next = !Bus2IP_Mst_CmdAck ? REQ : (Bus2IP_Mst_Cmplt ? PUSH : WAIT_CMPLT);
      WAIT_CMPLT: w_next = Bus2IP_Mst_Cmplt ? PUSH : WAIT_CMPLT;
      PUSH:       w_next = w_last ? DONE : WAIT_SPACE;
      default:    w_next = IDLE;
    endcase
  end
  // state, pixel counters, running address and captured color
  always_ff @(posedge PLB_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= FB_BASE;
      r_color <= '0;
    end else begin
      r_state <= w_next;
      if (w_st == IDLE && frame_start) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= FB_BASE;
      end
      if (w_cap) r_color <= Bus2IP_MstRd_d;
      if (w_st == PUSH) begin
        r_addr <= r_addr + 32'd4;
        r_x    <= w_xlast ? 16'd0 : r_x + 16'd1;
        r_y    <= w_xlast ? r_y + 16'd1 : r_y;
      end
      if (w_st == DONE) r_addr <= FB_BASE;
    end
  end
endmodule

// File: tb/tb_fb_reader.sv
// tb_fb_reader: directed checks of fb_reader on a 4x2 frame at base 0x1000
module tb_fb_reader;
  logic        PLB_clk = 0;
  logic        reset = 1;
  logic        frame_start = 0;
  logic        busy, frame_done, IP2Bus_MstRd_Req, fifo_wr_en;
  logic [3:0]  state;
  logic [31:0] IP2Bus_Mst_Addr;
  logic        Bus2IP_Mst_CmdAck = 0, Bus2IP_Mst_Cmplt = 0, fifo_full = 0;
  logic [31:0] Bus2IP_MstRd_d = 0;
  logic [95:0] fifo_data;
  int checks = 0, errors = 0;

  fb_reader #(.FB_BASE(32'h1000), .FB_WIDTH(4), .FB_HEIGHT(2)) dut (
    .PLB_clk(PLB_clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .state(state), .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req),
    .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr), .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck),
    .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt), .Bus2IP_MstRd_d(Bus2IP_MstRd_d),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .fifo_full(fifo_full)
  );

  always #5 PLB_clk = ~PLB_clk;

  task automatic step();
    @(posedge PLB_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input bit full_mode, input bit refire);
    int np = 0, nd = 0, hold = 0;
    bit pf = 0, fired = 0;
    logic [31:0] ea;
    frame_start = 1;
    step();
    frame_start = 0;
    chk("start_state", 96'(state), 96'(1));
    chk("start_busy", 96'(busy), 96'(1));
    for (int c = 0; c < 300 && nd == 0; c++) begin
      step();
      ea = 32'h1000 + 32'(np * 4);
      if (pf) chk("full_no_req", 96'(IP2Bus_MstRd_Req), 96'(0));
      if (IP2Bus_MstRd_Req && !Bus2IP_Mst_CmdAck) chk("req_addr", 96'(IP2Bus_Mst_Addr), 96'(ea));
      if (fifo_wr_en) begin
        chk("push_rec", fifo_data, {16'(np % 4), 16'(np / 4), 32'h0, ea});
        np++;
        if (full_mode && np == 3) hold = 10;
      end
      if (frame_done) nd++;
      frame_start = 0;
      if (refire && np == 2 && !fired) begin
        frame_start = 1;
        fired = 1;
      end
      fifo_full = hold > 0;
      if (hold > 0) hold--;
      pf = fifo_full;
      Bus2IP_Mst_CmdAck = IP2Bus_MstRd_Req && !Bus2IP_Mst_CmdAck;
      Bus2IP_Mst_Cmplt  = Bus2IP_Mst_CmdAck;
      Bus2IP_MstRd_d    = IP2Bus_Mst_Addr;
    end
    chk("frame_done_count", 96'(nd), 96'(1));
    chk("push_count", 96'(np), 96'(8));
    step();
    chk("done_one_cycle", 96'(frame_done), 96'(0));
    chk("end_state", 96'(state), 96'(0));
    chk("end_busy", 96'(busy), 96'(0));
    chk("end_addr", 96'(IP2Bus_Mst_Addr), 96'(32'h1000));
  endtask

  initial begin
    step();
    step();
    chk("rst_state", 96'(state), 96'(0));
    chk("rst_req", 96'(IP2Bus_MstRd_Req), 96'(0));
    chk("rst_wr_en", 96'(fifo_wr_en), 96'(0));
    chk("rst_done", 96'(frame_done), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_addr", 96'(IP2Bus_Mst_Addr), 96'(32'h1000));
    chk("rst_data", fifo_data, 96'(0));
    reset = 0;
    step();
    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(0, 1);
    run_frame(0, 0);
    frame_start = 1;
    step();
    frame_start = 0;
    step();
    chk("slow_req", 96'(IP2Bus_MstRd_Req), 96'(1));
    chk("slow_addr", 96'(IP2Bus_Mst_Addr), 96'(32'h1000));
    Bus2IP_Mst_CmdAck = 1;
    step();
    Bus2IP_Mst_CmdAck = 0;
    chk("slow_state_wait", 96'(state), 96'(3));
    chk("slow_req_drop", 96'(IP2Bus_MstRd_Req), 96'(0));
    for (int i = 0; i < 2; i++) begin
      step();
      chk("slow_no_req", 96'(IP2Bus_MstRd_Req), 96'(0));
      chk("slow_no_push", 96'(fifo_wr_en), 96'(0));
    end
    Bus2IP_Mst_Cmplt = 1;
    Bus2IP_MstRd_d = 32'hDEADBEEF;
    step();
    Bus2IP_Mst_Cmplt = 0;
    chk("slow_push", 96'(fifo_wr_en), 96'(1));
    chk("slow_rec", fifo_data, {16'd0, 16'd0, 32'h0, 32'hDEADBEEF});
    step();
    chk("slow_single_push", 96'(fifo_wr_en), 96'(0));
    step();
    chk("next_req", 96'(IP2Bus_MstRd_Req), 96'(1));
    chk("next_addr", 96'(IP2Bus_Mst_Addr), 96'(32'h1004));
    Bus2IP_Mst_CmdAck = 1;
    step();
    Bus2IP_Mst_CmdAck = 0;
    chk("next_state_wait", 96'(state), 96'(3));
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_state", 96'(state), 96'(0));
    chk("mid_rst_req", 96'(IP2Bus_MstRd_Req), 96'(0));
    chk("mid_rst_addr", 96'(IP2Bus_Mst_Addr), 96'(32'h1000));
    chk("mid_rst_data", fifo_data, 96'(0));
    Bus2IP_Mst_CmdAck = 1;
    Bus2IP_Mst_Cmplt = 1;
    Bus2IP_MstRd_d = 32'h12345678;
    step();
    Bus2IP_Mst_CmdAck = 0;
    Bus2IP_Mst_Cmplt = 0;
    chk("stray_no_push", 96'(fifo_wr_en), 96'(0));
    chk("stray_state", 96'(state), 96'(0));
    chk("stray_addr", 96'(IP2Bus_Mst_Addr), 96'(32'h1000));
    reset = 1;
    frame_start = 1;
    step();
    reset = 0;
    frame_start = 0;
    chk("rst_prio_state", 96'(state), 96'(0));
    chk("rst_prio_busy", 96'(busy), 96'(0));
    step();
    chk("rst_prio_stay_idle", 96'(state), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 Parameter FB_BASE, default 32'h0000_0000, byte address of pixel (0,0); SHALL be 4-byte aligned.
REQ-002 Parameter FB_WIDTH, default 640, pixels per line, range 1..65535.
REQ-003 Parameter FB_HEIGHT, default 480, lines per frame, range 1..65535.
REQ-004 PLB_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frame_start  in  1  one-cycle request to read one full frame.
REQ-007 busy  out  1  high while a frame read is in progress.
REQ-008 frame_done  out  1  one-cycle pulse after the last pixel is pushed.
REQ-009 state  out  4  current FSM state encoding, for debug.
REQ-010 IP2Bus_MstRd_Req  out  1  single-beat PLB master read request.
REQ-011 IP2Bus_Mst_Addr  out  32  read byte address.
REQ-012 Bus2IP_Mst_CmdAck  in  1  bus accepted the request.
REQ-013 Bus2IP_Mst_Cmplt  in  1  read complete; read data valid this cycle.
REQ-014 Bus2IP_MstRd_d  in  32  read data word (pixel color).
REQ-015 fifo_wr_en  out  1  push fifo_data into the pixel FIFO.
REQ-016 fifo_data  out  96  pixel record: [95:80]=x, [79:64]=y, [63:32]=32'h0, [31:0]=color.
REQ-017 fifo_full  in  1  pixel FIFO cannot accept a push.

Function
REQ-018 Encodings SHALL be IDLE=0, WAIT_SPACE=1, REQ=2, WAIT_CMPLT=3, PUSH=4, DONE=5; other values decode to IDLE.
REQ-019 IDLE: on frame_start, load x=0, y=0, addr=FB_BASE, then go to WAIT_SPACE; busy=1 in every state except IDLE.
REQ-020 frame_start while not in IDLE SHALL be ignored, with no effect on counters or address.
REQ-021 WAIT_SPACE: if fifo_full=0 go to REQ, otherwise hold; no bus request is issued while fifo_full=1.
REQ-022 REQ: IP2Bus_MstRd_Req=1 and IP2Bus_Mst_Addr=addr; both held stable until Bus2IP_Mst_CmdAck=1 is sampled.
REQ-023 REQ with CmdAck=1 and Cmplt=0: go to WAIT_CMPLT; Req=0 from the next cycle.
REQ-024 REQ with CmdAck=1 and Cmplt=1 in the same cycle: capture Bus2IP_MstRd_d and go directly to PUSH.
REQ-025 WAIT_CMPLT: on Cmplt=1, capture Bus2IP_MstRd_d into the color register and go to PUSH.
REQ-026 Cmplt without a prior or simultaneous CmdAck, or outside REQ/WAIT_CMPLT, SHALL be ignored.
REQ-027 PUSH: fifo_wr_en=1 for exactly one cycle, with fifo_data formed from the current x, y and captured color.
REQ-028 Space is guaranteed by REQ-021; PUSH SHALL NOT re-check fifo_full.
REQ-029 Advance after PUSH: addr+=4 (32-bit wrap); if x==FB_WIDTH-1 then x=0 and y+=1, else x+=1.
REQ-030 Last pixel (x==FB_WIDTH-1, y==FB_HEIGHT-1): PUSH goes to DONE; otherwise PUSH goes to WAIT_SPACE.
REQ-031 DONE: frame_done=1 for one cycle, then IDLE; addr returns to FB_BASE.
REQ-032 Minimum latency per pixel: 3 cycles (WAIT_SPACE, REQ with simultaneous ack+cmplt, PUSH).
REQ-033 Outstanding bus transactions SHALL be at most one.
REQ-034 x and y are 16-bit counters; addr is a running 32-bit counter with no multiplier.

Reset
REQ-035 While reset=1 at a clock edge: state=IDLE, IP2Bus_MstRd_Req=0, fifo_wr_en=0, frame_done=0, busy=0, IP2Bus_Mst_Addr=FB_BASE, x=0, y=0, color=0, fifo_data=0.
REQ-036 Reset mid-transaction SHALL abandon it: Req=0 and no push from the cycle after the reset edge; later CmdAck/Cmplt are ignored per REQ-026.
REQ-037 reset SHALL take priority over frame_start in the same cycle.

Verification (FB_WIDTH=4, FB_HEIGHT=2, FB_BASE=32'h1000)
REQ-038 Ack responder pulses CmdAck=Cmplt=1 one cycle after Req, data=addr; frame_start -> 8 pushes, addresses 1000..101C, records (x,y) (0,0)..(3,1) with color=address, then one frame_done pulse.
REQ-039 CmdAck one cycle, Cmplt 3 cycles later, data 32'hDEADBEEF -> Req drops after CmdAck, exactly one push with color DEADBEEF, no second request until the push.
REQ-040 fifo_full=1 for 10 cycles starting mid-frame -> no Req during that window; resumes at the next address with no skipped or duplicated pixel.
REQ-041 Reset asserted in WAIT_CMPLT, then a stray Cmplt -> no push, state=IDLE, Mst_Addr=32'h1000.
REQ-042 frame_start pulsed again while busy -> ignored, exactly 8 pushes; a new frame_start after frame_done restarts at 32'h1000.
